// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: NOP encoding, default reset PC and fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue holding {instruction, pc+4} pairs between instruction memory and IF/ID.
module fetch_fifo #(
  parameter int FQ_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  logic [63:0]                      push_data,
  input  logic                             pop,
  output logic [63:0]                      pop_data,
  output logic [$clog2(FQ_DEPTH+1)-1:0]    count,
  output logic                             full,
  output logic                             empty
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  logic [63:0]         mem_reg [FQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [FQ_DEPTH-1:0] wr_en;
  logic                do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_reg == CNT_W'(FQ_DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FQ_DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= push_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding memory request, fetch queue and IF/ID register.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Instr,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Addr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  fetch_state_e     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      if_id_instr_reg, if_id_instr_next;
  logic [31:0]      if_id_pc4_reg, if_id_pc4_next;
  logic             if_id_valid_reg, if_id_valid_next;

  logic [63:0]      fq_head;
  logic [CNT_W-1:0] fq_count;
  logic             fq_full, fq_empty;
  logic             im_req, waiting, push, pop;

  // DISCARD keeps the stale request alive until the memory acknowledges it.
  assign im_req  = !rst && ((state_reg == DISCARD) || (fq_count < CNT_W'(FQ_DEPTH)));
  assign waiting = im_req && !IM_Ack;
  assign push    = im_req && IM_Ack && (state_reg == FETCH) && !Redirect && !fq_full;
  assign pop     = !Redirect && !Stall;

  assign IM_Req      = im_req;
  assign IM_Addr     = addr_reg;
  assign IF_ID_Instr = if_id_instr_reg;
  assign IF_ID_PC4   = if_id_pc4_reg;
  assign IF_ID_Valid = if_id_valid_reg;

  fetch_fifo #(
    .FQ_DEPTH(FQ_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (Redirect),
    .push     (push),
    .push_data({IM_Instr, addr_reg + 32'd4}),
    .pop      (pop),
    .pop_data (fq_head),
    .count    (fq_count),
    .full     (fq_full),
    .empty    (fq_empty)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    case (state_reg)
      FETCH:   if (Redirect && waiting) state_next = DISCARD;
      DISCARD: if (im_req && IM_Ack)    state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (Redirect)  pc_next = word_align(Redirect_Addr);
    else if (push) pc_next = pc_reg + 32'd4;
    // The address only moves once the current request has been acknowledged.
    if (!waiting) addr_next = pc_next;
  end

  always_comb begin
    if_id_instr_next = if_id_instr_reg;
    if_id_pc4_next   = if_id_pc4_reg;
    if_id_valid_next = if_id_valid_reg;
    if (Redirect) begin
      if_id_instr_next = NOP_INSTR;
      if_id_valid_next = 1'b0;
    end else if (!Stall) begin
      if (!fq_empty) begin
        if_id_instr_next = fq_head[63:32];
        if_id_pc4_next   = fq_head[31:0];
        if_id_valid_next = 1'b1;
      end else begin
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= word_align(RESET_PC);
      addr_reg        <= word_align(RESET_PC);
      if_id_instr_reg <= NOP_INSTR;
      if_id_pc4_reg   <= 32'h0;
      if_id_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      addr_reg        <= addr_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_pc4_reg   <= if_id_pc4_next;
      if_id_valid_reg <= if_id_valid_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns ~address as the instruction word.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack = 1'b0;
  logic [31:0] IM_Instr = 32'h0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_Addr = 32'h0;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;

  int   n_checks = 0;
  int   n_errors = 0;
  logic rst_next = 1'b1;
  int   mem_lat  = 0;
  int   wait_cnt = 0;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .FQ_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IM_Req       (IM_Req),
    .IM_Addr      (IM_Addr),
    .IM_Ack       (IM_Ack),
    .IM_Instr     (IM_Instr),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .Redirect_Addr(Redirect_Addr),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Valid  (IF_ID_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory acks after mem_lat wait cycles of an active request.
  task automatic mem_update();
    if (IM_Req) begin
      if (wait_cnt >= mem_lat) begin
        IM_Ack   = 1'b1;
        IM_Instr = ~IM_Addr;
        wait_cnt = 0;
      end else begin
        IM_Ack   = 1'b0;
        IM_Instr = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      IM_Ack   = 1'b0;
      IM_Instr = 32'hDEAD_BEEF;
      wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    Redirect = 1'b0;
    rst      = rst_next;
    #1;
    mem_update();
  endtask

  task automatic reset_to_c0(input int lat);
    mem_lat  = lat;
    Stall    = 1'b0;
    rst_next = 1'b1;
    tick();
    tick();
    rst_next = 1'b0;
    tick();
  endtask

  initial begin
    // Reset, zero-wait streaming, stall hold
    mem_lat  = 0;
    rst_next = 1'b1;
    tick();
    chk("rst_req", IM_Req, 1'b0);
    chk("rst_instr", IF_ID_Instr, 32'h0);
    chk("rst_pc4", IF_ID_PC4, 32'h0);
    chk("rst_valid", IF_ID_Valid, 1'b0);
    rst_next = 1'b0;
    tick();                                   // c0
    chk("a_c0_req", IM_Req, 1'b1);
    chk("a_c0_addr", IM_Addr, 32'h0);
    tick();                                   // c1
    chk("a_c1_valid", IF_ID_Valid, 1'b0);
    chk("a_c1_addr", IM_Addr, 32'h4);
    tick();                                   // c2
    chk("a_c2_pc4", IF_ID_PC4, 32'h4);
    chk("a_c2_instr", IF_ID_Instr, 32'hFFFF_FFFF);
    chk("a_c2_valid", IF_ID_Valid, 1'b1);
    chk("a_c2_addr", IM_Addr, 32'h8);
    tick();                                   // c3
    chk("a_c3_pc4", IF_ID_PC4, 32'h8);
    chk("a_c3_instr", IF_ID_Instr, 32'hFFFF_FFFB);
    Stall = 1'b1;
    tick();                                   // c4
    chk("a_c4_req", IM_Req, 1'b0);
    chk("a_c4_pc4", IF_ID_PC4, 32'h8);
    tick();                                   // c5
    chk("a_c5_req", IM_Req, 1'b0);
    chk("a_c5_pc4", IF_ID_PC4, 32'h8);
    tick();                                   // c6
    Stall = 1'b0;
    chk("a_c6_pc4", IF_ID_PC4, 32'h8);
    tick();                                   // c7
    chk("a_c7_pc4", IF_ID_PC4, 32'hC);
    chk("a_c7_instr", IF_ID_Instr, 32'hFFFF_FFF7);
    chk("a_c7_addr", IM_Addr, 32'h10);
    tick();                                   // c8
    chk("a_c8_pc4", IF_ID_PC4, 32'h10);
    chk("a_c8_instr", IF_ID_Instr, 32'hFFFF_FFF3);
    // Fill the queue, then reset with a spurious ack in the reset cycle
    Stall = 1'b1;
    tick();                                   // c9
    chk("b_full_req", IM_Req, 1'b0);
    chk("b_full_pc4", IF_ID_PC4, 32'h10);
    rst_next = 1'b1;
    tick();                                   // c10, rst high
    IM_Ack   = 1'b1;
    IM_Instr = 32'h1234_5678;
    Stall    = 1'b0;
    chk("b_rst_req", IM_Req, 1'b0);
    rst_next = 1'b0;
    tick();                                   // c11
    chk("b_instr", IF_ID_Instr, 32'h0);
    chk("b_pc4", IF_ID_PC4, 32'h0);
    chk("b_valid", IF_ID_Valid, 1'b0);
    chk("b_req", IM_Req, 1'b1);
    chk("b_addr", IM_Addr, 32'h0);
    tick();
    chk("b_c12_valid", IF_ID_Valid, 1'b0);
    tick();
    chk("b_c13_pc4", IF_ID_PC4, 32'h4);
    chk("b_c13_instr", IF_ID_Instr, 32'hFFFF_FFFF);
    chk("b_c13_valid", IF_ID_Valid, 1'b1);

    // 3-cycle memory, redirect during the second wait cycle
    reset_to_c0(2);
    chk("c_c0_addr", IM_Addr, 32'h0);
    tick();
    tick();                                   // c2 ack
    tick();                                   // c3
    chk("c_c3_valid", IF_ID_Valid, 1'b0);
    tick();                                   // c4
    chk("c_c4_pc4", IF_ID_PC4, 32'h4);
    chk("c_c4_valid", IF_ID_Valid, 1'b1);
    Redirect      = 1'b1;
    Redirect_Addr = 32'h100;
    tick();                                   // c5, discard
    chk("c_c5_addr", IM_Addr, 32'h4);
    chk("c_c5_req", IM_Req, 1'b1);
    chk("c_c5_valid", IF_ID_Valid, 1'b0);
    chk("c_c5_instr", IF_ID_Instr, 32'h0);
    tick();                                   // c6
    chk("c_c6_addr", IM_Addr, 32'h100);
    chk("c_c6_valid", IF_ID_Valid, 1'b0);
    for (int i = 7; i <= 9; i++) begin
      tick();
      chk($sformatf("c_c%0d_valid", i), IF_ID_Valid, 1'b0);
    end
    tick();                                   // c10
    chk("c_c10_pc4", IF_ID_PC4, 32'h104);
    chk("c_c10_instr", IF_ID_Instr, 32'hFFFF_FEFF);
    chk("c_c10_valid", IF_ID_Valid, 1'b1);

    // Redirect coincident with ack
    reset_to_c0(0);
    Redirect      = 1'b1;
    Redirect_Addr = 32'h40;
    tick();
    chk("d_c1_addr", IM_Addr, 32'h40);
    chk("d_c1_valid", IF_ID_Valid, 1'b0);
    tick();
    chk("d_c2_addr", IM_Addr, 32'h44);
    chk("d_c2_valid", IF_ID_Valid, 1'b0);
    tick();
    chk("d_c3_pc4", IF_ID_PC4, 32'h44);
    chk("d_c3_instr", IF_ID_Instr, 32'hFFFF_FFBF);
    chk("d_c3_valid", IF_ID_Valid, 1'b1);

    // Unaligned redirect target and PC wrap
    reset_to_c0(0);
    Redirect      = 1'b1;
    Redirect_Addr = 32'h203;
    tick();
    chk("e_align_addr", IM_Addr, 32'h200);
    Redirect      = 1'b1;
    Redirect_Addr = 32'hFFFF_FFFD;
    tick();
    chk("e_top_addr", IM_Addr, 32'hFFFF_FFFC);
    tick();
    chk("e_wrap_addr", IM_Addr, 32'h0);
    tick();
    chk("e_wrap_pc4", IF_ID_PC4, 32'h0);
    chk("e_wrap_instr", IF_ID_Instr, 32'h3);
    chk("e_wrap_valid", IF_ID_Valid, 1'b1);

    // Back-to-back redirects while waiting: last one wins
    reset_to_c0(3);
    chk("f_c0_addr", IM_Addr, 32'h0);
    tick();                                   // c1
    Redirect      = 1'b1;
    Redirect_Addr = 32'h300;
    tick();                                   // c2
    chk("f_c2_addr", IM_Addr, 32'h0);
    Redirect      = 1'b1;
    Redirect_Addr = 32'h500;
    tick();                                   // c3, stale ack
    chk("f_c3_addr", IM_Addr, 32'h0);
    tick();                                   // c4
    chk("f_c4_addr", IM_Addr, 32'h500);
    chk("f_c4_valid", IF_ID_Valid, 1'b0);
    for (int i = 5; i <= 8; i++) begin
      tick();
      chk($sformatf("f_c%0d_valid", i), IF_ID_Valid, 1'b0);
    end
    tick();                                   // c9
    chk("f_c9_pc4", IF_ID_PC4, 32'h504);
    chk("f_c9_instr", IF_ID_Instr, 32'hFFFF_FAFF);
    chk("f_c9_valid", IF_ID_Valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
